// File: rtl/ovi_vpu_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ovi_vpu_responder_pkg
//  Description : OVI bus typedefs plus the responder's FSM state enum and
//                issue-queue entry struct.
//  Revision    : 1.0 - initial release
// ============================================================================
package ovi_vpu_responder_pkg;

    localparam int SB_ID_W = 5;

    // Vector CSR snapshot carried with every issued instruction
    typedef struct packed {
        logic [14:0] vl;
        logic        vill;
        logic [7:0]  vtype;
        logic [1:0]  vxrm;
        logic [2:0]  frm;
    } vcsr_t;

    typedef struct packed {
        logic               valid;
        logic [31:0]        instr;
        logic [63:0]        scalar_opnd;
        logic [SB_ID_W-1:0] sb_id;
        vcsr_t              vcsr;
    } vpu_issue_bus;

    typedef struct packed {
        logic [SB_ID_W-1:0] sb_id;
        logic               next_senior;
        logic               kill;
    } vpu_dispatch_bus;

    typedef struct packed {
        logic               valid;
        logic [SB_ID_W-1:0] sb_id;
        logic [63:0]        dest_reg;
        logic               illegal;
        logic [13:0]        vstart;
        logic               vxsat;
        logic [4:0]         fflags;
    } vpu_completed_bus;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_COMPLETE = 2'd2
    } resp_state_t;

    typedef struct packed {
        logic [31:0]        instr;
        logic [63:0]        scalar_opnd;
        logic [SB_ID_W-1:0] sb_id;
        vcsr_t              vcsr;
        logic               senior;
    } queue_entry_t;

endpackage : ovi_vpu_responder_pkg
`default_nettype wire

// File: rtl/ovi_vpu_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ovi_vpu_responder_if
//  Description : Core <-> VPU OVI signal bundle. The master modport is the
//                core side, the slave modport is the VPU responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ovi_vpu_responder_if;
    import ovi_vpu_responder_pkg::*;

    vpu_issue_bus     issue;
    vpu_dispatch_bus  dispatch;
    logic             issue_credit;
    vpu_completed_bus completed;
    logic             sync_start;
    logic             err;

    modport master (
        output issue,
        output dispatch,
        input  issue_credit,
        input  completed,
        input  sync_start,
        input  err
    );

    modport slave (
        input  issue,
        input  dispatch,
        output issue_credit,
        output completed,
        output sync_start,
        output err
    );

endinterface : ovi_vpu_responder_if
`default_nettype wire

// File: rtl/ovi_issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ovi_issue_fifo
//  Description : Generic issue queue with a wrap bit on each pointer so that
//                full and empty are distinguishable. Every slot is visible and
//                can be overwritten in place so the owner can update entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module ovi_issue_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  wire              clk,
    input  wire              rst_n,
    input  wire              push,
    input  T                 push_data,
    input  wire              pop,
    input  wire [DEPTH-1:0]  upd_en,
    input  T                 upd_data [DEPTH],
    output logic             full,
    output logic             empty,
    output T                 head,
    output T                 slots [DEPTH]
);

    localparam int                IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  C_LAST = IDX_W'(DEPTH - 1);

    T                 r_mem [DEPTH];
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic             r_wr_wrap;
    logic             r_rd_wrap;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_idx == r_rd_idx) && (r_wr_wrap == r_rd_wrap);
    assign full      = (r_wr_idx == r_rd_idx) && (r_wr_wrap != r_rd_wrap);
    assign w_do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rd_idx];
    assign slots     = r_mem;

    // Pointer update, wrapping modulo DEPTH and toggling the wrap bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx  <= '0;
            r_wr_wrap <= 1'b0;
            r_rd_idx  <= '0;
            r_rd_wrap <= 1'b0;
        end else begin
            if (w_do_push) begin
                if (r_wr_idx == C_LAST) begin
                    r_wr_idx  <= '0;
                    r_wr_wrap <= ~r_wr_wrap;
                end else begin
                    r_wr_idx  <= r_wr_idx + 1'b1;
                end
            end
            if (w_do_pop) begin
                if (r_rd_idx == C_LAST) begin
                    r_rd_idx  <= '0;
                    r_rd_wrap <= ~r_rd_wrap;
                end else begin
                    r_rd_idx  <= r_rd_idx + 1'b1;
                end
            end
        end
    end

    // Slot storage: a push into a slot overrides an in-place update of it
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_do_push && (r_wr_idx == IDX_W'(i))) begin
                r_mem[i] <= push_data;
            end else if (upd_en[i]) begin
                r_mem[i] <= upd_data[i];
            end
        end
    end

endmodule : ovi_issue_fifo
`default_nettype wire

// File: rtl/ovi_vpu_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ovi_vpu_responder
//  Description : Minimal OVI VPU model. Queues issued instructions, waits for
//                each to become senior (or be killed at the head), executes for
//                a fixed latency and reports a completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module ovi_vpu_responder
    import ovi_vpu_responder_pkg::*;
#(
    parameter int QUEUE_DEPTH  = 4,
    parameter int EXEC_LATENCY = 3
) (
    input  wire                 clk,
    input  wire                 rst_n,
    ovi_vpu_responder_if.slave  bus
);

    localparam logic [3:0] c_cnt_load = 4'(EXEC_LATENCY - 1);

    resp_state_t              r_state;
    resp_state_t              w_state_nxt;
    logic [3:0]               r_cnt;
    logic [3:0]               w_cnt_nxt;
    queue_entry_t             r_exec;
    logic                     r_credit;
    logic                     r_err;

    queue_entry_t             w_push_entry;
    queue_entry_t             w_head;
    queue_entry_t             w_slots    [QUEUE_DEPTH];
    queue_entry_t             w_upd_data [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]   w_upd_en;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_kill_pop;
    logic                     w_start_pop;
    logic                     w_pop;
    logic                     w_drop;
    logic                     w_unused;

    // Build the pushed entry and the per-slot senior updates; an entry pushed
    // in the same cycle as a matching next_senior is born senior
    always_comb begin
        w_push_entry.instr       = bus.issue.instr;
        w_push_entry.scalar_opnd = bus.issue.scalar_opnd;
        w_push_entry.sb_id       = bus.issue.sb_id;
        w_push_entry.vcsr        = bus.issue.vcsr;
        w_push_entry.senior      = bus.dispatch.next_senior &&
                                   (bus.dispatch.sb_id == bus.issue.sb_id);
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            w_upd_data[i]        = w_slots[i];
            w_upd_data[i].senior = 1'b1;
            w_upd_en[i]          = bus.dispatch.next_senior &&
                                   (w_slots[i].sb_id == bus.dispatch.sb_id);
        end
    end

    // Kill at the head takes priority over starting execution
    assign w_kill_pop  = bus.dispatch.kill && !w_empty &&
                         (w_head.sb_id == bus.dispatch.sb_id);
    assign w_start_pop = (r_state == ST_IDLE) && !w_empty && w_head.senior &&
                         !w_kill_pop;
    assign w_pop       = w_kill_pop || w_start_pop;
    assign w_drop      = bus.issue.valid && w_full && !w_pop;

    ovi_issue_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .T     (queue_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.issue.valid),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .upd_en    (w_upd_en),
        .upd_data  (w_upd_data),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head),
        .slots     (w_slots)
    );

    // State, latency counter, execute register, credit pulse and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_exec   <= '0;
            r_credit <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_credit <= w_pop;
            r_err    <= r_err || w_drop;
            if (w_start_pop) begin
                r_exec <= w_head;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start_pop) begin
                    w_state_nxt = ST_EXEC;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            ST_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_COMPLETE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_COMPLETE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Completion report: all fields zero outside the COMPLETE cycle
    always_comb begin
        bus.completed = '0;
        if (r_state == ST_COMPLETE) begin
            bus.completed.valid    = 1'b1;
            bus.completed.sb_id    = r_exec.sb_id;
            bus.completed.dest_reg = r_exec.scalar_opnd + 64'(r_exec.vcsr.vl);
            bus.completed.illegal  = r_exec.vcsr.vill;
        end
    end

    assign bus.issue_credit = r_credit;
    assign bus.err          = r_err;
    assign bus.sync_start   = 1'b0;

    // Instruction word and remaining CSR fields ride along but are not reported
    assign w_unused = ^r_exec;

endmodule : ovi_vpu_responder
`default_nettype wire

// File: tb/tb_ovi_vpu_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ovi_vpu_responder
//  Description : Directed and randomized self-checking bench for the responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ovi_vpu_responder;
    import ovi_vpu_responder_pkg::*;

    localparam int DEPTH  = 4;
    localparam int LAT    = 3;
    localparam int SPACE  = LAT + 2;

    typedef struct {
        int          t;
        logic [4:0]  sb;
        logic [63:0] dest;
        logic        ill;
        logic [19:0] zero_fields;
    } comp_t;

    typedef struct {
        logic [4:0]  sb;
        logic [63:0] dest;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   idle_nonzero = 0;
    int   sync_nonzero = 0;
    comp_t comp_q[$];
    int    credit_q[$];
    exp_t  exp_q[$];

    ovi_vpu_responder_if bus();

    ovi_vpu_responder #(
        .QUEUE_DEPTH  (DEPTH),
        .EXEC_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Cycle index advances at each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Record completions and credits; count idle-field and sync_start violations
    always @(negedge clk) begin
        if (bus.completed.valid === 1'b1) begin
            comp_q.push_back('{t: cyc, sb: bus.completed.sb_id,
                               dest: bus.completed.dest_reg,
                               ill: bus.completed.illegal,
                               zero_fields: {bus.completed.vstart, bus.completed.vxsat,
                                             bus.completed.fflags}});
        end else if (bus.completed !== '0) begin
            idle_nonzero++;
        end
        if (bus.issue_credit === 1'b1) credit_q.push_back(cyc);
        if (bus.sync_start !== 1'b0) sync_nonzero++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.issue    = '0;
        bus.dispatch = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic clear_logs();
        comp_q.delete();
        credit_q.delete();
        exp_q.delete();
    endtask

    // Drive one issue in the current cycle; optionally mark it senior at once
    task automatic drive_issue(input logic [4:0] sb, input logic [63:0] opnd,
                               input logic [14:0] vl, input logic vill,
                               input logic senior, input logic expect_done);
        bus.issue.valid          = 1'b1;
        bus.issue.instr          = $urandom;
        bus.issue.scalar_opnd    = opnd;
        bus.issue.sb_id          = sb;
        bus.issue.vcsr.vl        = vl;
        bus.issue.vcsr.vill      = vill;
        bus.issue.vcsr.vtype     = 8'($urandom);
        bus.issue.vcsr.vxrm      = 2'($urandom);
        bus.issue.vcsr.frm       = 3'($urandom);
        if (senior) begin
            bus.dispatch.next_senior = 1'b1;
            bus.dispatch.sb_id       = sb;
        end
        if (expect_done) exp_q.push_back('{sb: sb, dest: opnd + {49'd0, vl}, ill: vill});
    endtask

    task automatic check_completions(input string tag);
        check({tag, "_count"}, 64'(comp_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < comp_q.size(); i++) begin
            check({tag, "_sb"},   64'(comp_q[i].sb),   64'(exp_q[i].sb));
            check({tag, "_dest"}, comp_q[i].dest,      exp_q[i].dest);
            check({tag, "_ill"},  64'(comp_q[i].ill),  64'(exp_q[i].ill));
            check({tag, "_zero"}, 64'(comp_q[i].zero_fields), 64'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_credit"}, 64'(bus.issue_credit), 64'd0);
        check({tag, "_completed"}, 64'(bus.completed != '0), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
        check({tag, "_sync"}, 64'(bus.sync_start), 64'd0);
    endtask

    initial begin
        int t0;
        logic [63:0] opnd;
        logic [4:0]  base;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");

        // Single op, issued in the first cycle after reset release
        rst_n = 1'b1;
        clear_logs();
        t0 = cyc;
        drive_issue(5'd1, 64'd5, 15'd8, 1'b0, 1'b1, 1'b1);
        wait_cycles(8);
        check("single_credit_count", 64'(credit_q.size()), 64'd1);
        if (credit_q.size() > 0) check("single_credit_time", 64'(credit_q[0]), 64'(t0 + 2));
        if (comp_q.size() > 0) check("single_comp_time", 64'(comp_q[0].t), 64'(t0 + LAT + 2));
        check("single_dest_13", comp_q.size() > 0 ? comp_q[0].dest : 64'hX, 64'd13);
        check_completions("single");
        check("single_err", 64'(bus.err), 64'd0);

        // Fill to full, overflow, then release in order
        clear_logs();
        for (int i = 0; i < DEPTH; i++) begin
            opnd = (i == 3) ? 64'hFFFF_FFFF_FFFF_FFFE : {$urandom, $urandom};
            drive_issue(5'(i), opnd, (i == 3) ? 15'd5 : 15'($urandom_range(0, 32767)),
                        (i == 2), 1'b0, 1'b1);
            step();
        end
        check("full_no_err", 64'(bus.err), 64'd0);
        drive_issue(5'd4, 64'd99, 15'd1, 1'b0, 1'b0, 1'b0);
        step();
        check("overflow_err", 64'(bus.err), 64'd1);
        check("overflow_no_credit", 64'(credit_q.size()), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            bus.dispatch.next_senior = 1'b1;
            bus.dispatch.sb_id       = 5'(i);
            step();
        end
        wait_cycles(DEPTH * SPACE + 6);
        check_completions("fill");
        check("fill_credits", 64'(credit_q.size()), 64'(DEPTH));
        check("err_sticky", 64'(bus.err), 64'd1);

        // Reset clears the sticky error
        rst_n = 1'b0;
        #1;
        check("err_reset", 64'(bus.err), 64'd0);
        step();
        rst_n = 1'b1;

        // Kill beats start on a senior head; next issue runs normally
        clear_logs();
        t0 = cyc;
        drive_issue(5'd2, 64'd7, 15'd3, 1'b0, 1'b1, 1'b0);
        step();
        bus.dispatch.kill  = 1'b1;
        bus.dispatch.sb_id = 5'd2;
        step();
        drive_issue(5'd6, {$urandom, $urandom}, 15'($urandom_range(0, 32767)), 1'b0, 1'b1, 1'b1);
        wait_cycles(9);
        check("kill_credit_count", 64'(credit_q.size()), 64'd2);
        if (credit_q.size() > 1) begin
            check("kill_credit_time", 64'(credit_q[0]), 64'(t0 + 2));
            check("after_kill_credit_time", 64'(credit_q[1]), 64'(t0 + 4));
        end
        if (comp_q.size() > 0) check("after_kill_comp_time", 64'(comp_q[0].t), 64'(t0 + 2 + SPACE));
        check_completions("kill");

        // Full queue: push with same-cycle kill pop; kill of a non-head ignored
        clear_logs();
        for (int i = 0; i < DEPTH; i++) begin
            drive_issue(5'(10 + i), {$urandom, $urandom}, 15'($urandom_range(0, 32767)),
                        1'b0, 1'b0, (i != 0));
            step();
        end
        drive_issue(5'd14, {$urandom, $urandom}, 15'($urandom_range(0, 32767)), 1'b1, 1'b0, 1'b1);
        bus.dispatch.kill  = 1'b1;
        bus.dispatch.sb_id = 5'd10;
        step();
        check("full_pushpop_no_err", 64'(bus.err), 64'd0);
        bus.dispatch.kill  = 1'b1;
        bus.dispatch.sb_id = 5'd12;
        step();
        for (int i = 11; i <= 14; i++) begin
            bus.dispatch.next_senior = 1'b1;
            bus.dispatch.sb_id       = 5'(i);
            step();
        end
        wait_cycles(DEPTH * SPACE + 6);
        check_completions("nonhead_kill");
        check("nonhead_kill_credits", 64'(credit_q.size()), 64'd5);
        check("nonhead_kill_err", 64'(bus.err), 64'd0);

        // Randomized back-to-back rounds of three senior issues
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            base = 5'($urandom_range(0, 31));
            t0 = cyc;
            for (int i = 0; i < 3; i++) begin
                drive_issue(base + 5'(i * 7), {$urandom, $urandom},
                            15'($urandom_range(0, 32767)), 1'($urandom), 1'b1, 1'b1);
                step();
            end
            wait_cycles(3 * SPACE + 2);
            check_completions("b2b");
            check("b2b_credits", 64'(credit_q.size()), 64'd3);
            for (int i = 0; i < 3 && i < comp_q.size(); i++)
                check("b2b_comp_time", 64'(comp_q[i].t), 64'(t0 + SPACE * (i + 1)));
            for (int i = 0; i < 3 && i < credit_q.size(); i++)
                check("b2b_credit_time", 64'(credit_q[i]), 64'(t0 + 2 + SPACE * i));
        end

        // Reset in the middle of EXEC
        clear_logs();
        drive_issue(5'd1, 64'd5, 15'd8, 1'b0, 1'b1, 1'b0);
        wait_cycles(3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        step();
        rst_n = 1'b1;
        clear_logs();
        t0 = cyc;
        drive_issue(5'd7, 64'd100, 15'd20, 1'b0, 1'b1, 1'b1);
        wait_cycles(9);
        check_completions("post_reset");
        if (comp_q.size() > 0) check("post_reset_comp_time", 64'(comp_q[0].t), 64'(t0 + LAT + 2));
        check("post_reset_credits", 64'(credit_q.size()), 64'd1);

        check("idle_fields_zero", 64'(idle_nonzero), 64'd0);
        check("sync_start_zero", 64'(sync_nonzero), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ovi_vpu_responder
`default_nettype wire
